perceptron_array: RTL and testbench
===================================

// Module: perceptron_array
// PURPOSE
//  Multi-class bit-serial perceptron classifier: N_CLASSES weight sets are scored against one WIDTH-bit binary image.
//  Each class score = sum of signed weights where the image bit is 1 (plus optional bias); argmax selects the class.
//  Successor to the single-output perceptron: runtime-loadable signed weights, N classes, valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH      25  input image bits (5x5 default)
//  N_CLASSES  2   number of classes scored in parallel (>=2)
//  WEIGHT_W   4   signed weight width (two's complement)
// PORTS
//  clk        in   1                    single clock, all logic on posedge
//  rst_n      in   1                    synchronous active-low reset
//  in         in   WIDTH                image; bit 0 processed first
//  in_valid   in   1                    image offered
//  in_ready   out  1                    image accepted when in_valid && in_ready
//  w_we       in   1                    weight write strobe
//  w_class    in   CLS_W                target class, CLS_W = max(1,$clog2(N_CLASSES))
//  w_idx      in   IDX_W                bit index 0..WIDTH-1; WIDTH = bias slot; IDX_W = $clog2(WIDTH+1)
//  w_data     in   WEIGHT_W             signed weight/bias value
//  w_err      out  1                    1-cycle pulse: write rejected
//  out_valid  out  1                    result available
//  out_ready  in   1                    result consumed when out_valid && out_ready
//  out_class  out  CLS_W                winning class index
//  out_score  out  ACC_W                winning signed score, ACC_W = WEIGHT_W + $clog2(WIDTH+1) + 1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; in_ready=0 during reset, 1 first cycle after; out_valid=0; out_class=0;
//   out_score=0; w_err=0; all weights and biases cleared to 0. Reset mid-operation discards the image, no result.
//  FSM IDLE -> ACCUM -> COMPARE -> DONE -> IDLE.
//   IDLE: in_ready=1; on in_valid capture `in` into shift reg, load accumulators (bias or 0), go ACCUM.
//   ACCUM: WIDTH cycles; cycle k adds weight[c][k] to acc[c] for every class c if in[k]=1.
//   COMPARE: N_CLASSES-1 cycles; serial scan c=1..N-1, replace best only on strictly greater (ties -> lowest index).
//   DONE: out_valid=1, out_class/out_score stable; leave on out_ready, back to IDLE same edge.
//  Latency accept -> out_valid: WIDTH + N_CLASSES cycles. in_ready=0 in all states but IDLE (no overlap).
//  Weight writes: accepted only in IDLE with w_idx < WIDTH (or == WIDTH under bias macro); applied next edge.
//   Write in any other state or with out-of-range w_idx/w_class: ignored, w_err pulses next cycle.
//   Write and in_valid in same IDLE cycle: write lands; the captured image uses the NEW weights.
//  Arithmetic: weights sign-extended to ACC_W; ACC_W sized so no overflow possible; no saturation.
// CONFIGURATION
//  PERCEPTRON_ARRAY_BIAS_EN defined: per-class signed bias register (w_idx==WIDTH), preloaded into acc at accept.
//  Undefined: no bias storage, acc starts at 0, w_idx==WIDTH is out of range -> w_err.
// STRUCTURE
//  perceptron_pkg: state enum (IDLE, ACCUM, COMPARE, DONE), clog2-based width helper functions for CLS_W/IDX_W/ACC_W.
//  Sub-module perceptron_mac: one class's weight row + accumulator; generate-instantiated N_CLASSES times.
//  Top holds FSM, input shift register, bit counter, argmax compare, handshake.
// TESTING (WIDTH=25, N_CLASSES=2, WEIGHT_W=4)
//  1 Class0 w=+1 on bits of 25'h0454544, class1 w=+1 on bits of 25'h1155151; in=25'h0454544 -> class 0, score 8.
//  2 Class0 all -1, class1 all +1; in=25'h1FFFFFF -> class 1, score 25; out_valid exactly 27 cycles after accept.
//  3 All weights 0, in=0 -> tie -> class 0, score 0.
//  4 out_ready=0 for 10 cycles in DONE -> out_valid/out_class/out_score held, in_ready=0, second in_valid not taken.
//  5 w_we during ACCUM -> w_err pulse, weight unchanged (rerun of scenario 1 gives same result);
//    rst_n=0 at ACCUM cycle 10 -> no out_valid, next classification scores 0, class 0.
//  6 BIAS_EN: class1 bias=+3, in=0 -> class 1, score 3; without macro same write -> w_err, class 0, score 0.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types and width helpers for the multi-class bit-serial perceptron.
package perceptron_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    COMPARE,
    DONE
  } state_t;

  function automatic int cls_w(input int n_classes);
    int w;
    w = $clog2(n_classes);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int idx_w(input int width);
    return $clog2(width + 1);
  endfunction

  // One extra bit on top of the worst-case sum keeps the signed range safe.
  function automatic int acc_w(input int weight_w, input int width);
    return weight_w + $clog2(width + 1) + 1;
  endfunction

endpackage

// File: rtl/perceptron_mac.sv
// One class: signed weight row, optional bias register and the running score.
// Bias storage exists only when PERCEPTRON_ARRAY_BIAS_EN is defined.
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int WIDTH    = 25,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W   = idx_w(WIDTH),
  localparam int ACC_W   = acc_w(WEIGHT_W, WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_we,
  input  logic [IDX_W-1:0]           w_idx,
  input  logic signed [WEIGHT_W-1:0] w_data,
  input  logic                       load,
  input  logic                       add_en,
  input  logic [IDX_W-1:0]           bit_idx,
  output logic signed [ACC_W-1:0]    acc
);

  logic signed [WEIGHT_W-1:0] weight [WIDTH];
  logic signed [WEIGHT_W-1:0] cur_w;
  logic signed [WEIGHT_W-1:0] load_val;

  // NOTE: weights are runtime state that must read as zero after reset, so
  // this register array is reset explicitly instead of left to power-up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) weight[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (w_we && w_idx == IDX_W'(i)) weight[i] <= w_data;
    end
  end

`ifdef PERCEPTRON_ARRAY_BIAS_EN
  logic signed [WEIGHT_W-1:0] bias;

  always_ff @(posedge clk) begin
    if (!rst_n)                                 bias <= '0;
    else if (w_we && w_idx == IDX_W'(WIDTH))    bias <= w_data;
  end

  // A bias written on the accept edge must already seed this image.
  assign load_val = (w_we && w_idx == IDX_W'(WIDTH)) ? w_data : bias;
`else
  assign load_val = '0;
`endif

  assign cur_w = weight[bit_idx];

  always_ff @(posedge clk) begin
    if (!rst_n)
      acc <= '0;
    else if (load)
      acc <= $signed({{(ACC_W-WEIGHT_W){load_val[WEIGHT_W-1]}}, load_val});
    else if (add_en)
      acc <= acc + $signed({{(ACC_W-WEIGHT_W){cur_w[WEIGHT_W-1]}}, cur_w});
  end

endmodule

// File: rtl/perceptron_array.sv
// Multi-class bit-serial perceptron: FSM, image shift register, argmax and handshakes.
// Optional per-class bias enabled by defining PERCEPTRON_ARRAY_BIAS_EN.
module perceptron_array
  import perceptron_pkg::*;
#(
  parameter int WIDTH     = 25,
  parameter int N_CLASSES = 2,
  parameter int WEIGHT_W  = 4,
  localparam int CLS_W    = cls_w(N_CLASSES),
  localparam int IDX_W    = idx_w(WIDTH),
  localparam int ACC_W    = acc_w(WEIGHT_W, WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       w_we,
  input  logic [CLS_W-1:0]           w_class,
  input  logic [IDX_W-1:0]           w_idx,
  input  logic signed [WEIGHT_W-1:0] w_data,
  output logic                       w_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLS_W-1:0]           out_class,
  output logic signed [ACC_W-1:0]    out_score
);

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        shreg;
  logic [IDX_W-1:0]        bit_cnt;
  logic [CLS_W-1:0]        cmp_idx;
  logic signed [ACC_W-1:0] acc [N_CLASSES];
  logic [CLS_W-1:0]        best_class, cand_class;
  logic signed [ACC_W-1:0] best_score, cand_score;
  logic                    accept, idx_ok, cls_ok, w_ok;

  assign in_ready = rst_n && (state == IDLE);
  assign accept   = in_valid && in_ready;

`ifdef PERCEPTRON_ARRAY_BIAS_EN
  assign idx_ok = int'(w_idx) <= WIDTH;
`else
  assign idx_ok = int'(w_idx) < WIDTH;
`endif
  assign cls_ok = int'(w_class) < N_CLASSES;
  assign w_ok   = w_we && (state == IDLE) && idx_ok && cls_ok;

  for (genvar c = 0; c < N_CLASSES; c++) begin : g_mac
    perceptron_mac #(
      .WIDTH    (WIDTH),
      .WEIGHT_W (WEIGHT_W)
    ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .w_we    (w_ok && (w_class == CLS_W'(c))),
      .w_idx   (w_idx),
      .w_data  (w_data),
      .load    (accept),
      .add_en  ((state == ACCUM) && shreg[0]),
      .bit_idx (bit_cnt),
      .acc     (acc[c])
    );
  end

  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)                              state_nxt = ACCUM;
      ACCUM:   if (bit_cnt == IDX_W'(WIDTH - 1))          state_nxt = COMPARE;
      COMPARE: if (cmp_idx == CLS_W'(N_CLASSES - 1))      state_nxt = DONE;
      DONE:    if (out_ready)                             state_nxt = IDLE;
      default:                                            state_nxt = IDLE;
    endcase
  end

  // The first compare step seeds from class 0; strict > keeps ties on the lower index.
  always_comb begin
    cand_class = best_class;
    cand_score = best_score;
    if (cmp_idx == CLS_W'(1)) begin
      cand_class = '0;
      cand_score = acc[0];
    end
    if (acc[cmp_idx] > cand_score) begin
      cand_class = cmp_idx;
      cand_score = acc[cmp_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      cmp_idx    <= CLS_W'(1);
      best_class <= '0;
      best_score <= '0;
      w_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      w_err <= w_we && !w_ok;
      unique case (state)
        IDLE: if (accept) begin
          shreg   <= in;
          bit_cnt <= '0;
          cmp_idx <= CLS_W'(1);
        end
        ACCUM: begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + IDX_W'(1);
        end
        COMPARE: begin
          best_class <= cand_class;
          best_score <= cand_score;
          cmp_idx    <= cmp_idx + CLS_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign out_class = best_class;
  assign out_score = best_score;

endmodule

// File: tb/tb_perceptron_array.sv
// Self-checking bench for perceptron_array: table vectors, scoreboard queue and
// hand-written sequences for hold, write rejection, mid-run reset and bias.
module tb_perceptron_array;

  localparam int WIDTH     = 25;
  localparam int N_CLASSES = 2;
  localparam int M_NORM    = 0;
  localparam int M_WRITE   = 1;
  localparam int M_RESET   = 2;
  localparam int M_SAME    = 3;

  typedef struct {
    int cls;
    int score;
  } exp_t;

  typedef struct {
    int          setup;
    logic [24:0] img;
    int          cls;
    int          score;
  } vec_t;

  logic               clk_tb = 1'b0;
  logic               rst_n;
  logic [24:0]        in_data;
  logic               in_valid;
  logic               in_ready;
  logic               w_we;
  logic [0:0]         w_class;
  logic [4:0]         w_idx;
  logic [3:0]         w_data;
  logic               w_err;
  logic               out_valid;
  logic               out_ready;
  logic [0:0]         out_class;
  logic signed [9:0]  out_score;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  int   mw [2][25];
  int   mb [2];
  logic [24:0] pat0 = 25'h0454544;
  logic [24:0] pat1 = 25'h1155151;
  vec_t tbl [8];

  perceptron_array #(
    .WIDTH     (WIDTH),
    .N_CLASSES (N_CLASSES),
    .WEIGHT_W  (4)
  ) dut (
    .clk       (clk_tb),
    .rst_n     (rst_n),
    .in        (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w_we      (w_we),
    .w_class   (w_class),
    .w_idx     (w_idx),
    .w_data    (w_data),
    .w_err     (w_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [24:0] img);
    exp_t e;
    int   s [2];
    for (int c = 0; c < 2; c++) begin
      s[c] = mb[c];
      for (int k = 0; k < 25; k++) if (img[k]) s[c] += mw[c][k];
    end
    e.cls = 0;
    e.score = s[0];
    for (int c = 1; c < 2; c++)
      if (s[c] > e.score) begin
        e.cls = c;
        e.score = s[c];
      end
    return e;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < 2; c++) begin
      mb[c] = 0;
      for (int k = 0; k < 25; k++) mw[c][k] = 0;
    end
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic write_w(input int c, input int idx, input int d, input bit exp_err);
    w_we = 1'b1; w_class = c[0:0]; w_idx = idx[4:0]; w_data = d[3:0];
    @(posedge clk_tb);
    @(negedge clk_tb);
    w_we = 1'b0;
    check("w_err", w_err, exp_err);
    if (!exp_err) begin
      if (idx < 25) mw[c][idx] = d;
      else          mb[c] = d;
    end
  endtask

  task automatic set_weights(input int setup);
    int d;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 25; k++) begin
        case (setup)
          0:       d = (c == 0) ? int'(pat0[k]) : int'(pat1[k]);
          1:       d = (c == 0) ? -1 : 1;
          3:       d = int'($urandom_range(0, 15)) - 8;
          default: d = 0;
        endcase
        write_w(c, k, d, 1'b0);
      end
  endtask

  task automatic run_image(input logic [24:0] img, input exp_t e, input int mode,
                           input int wc, input int wi, input int wd);
    exp_t got;
    int   n;
    check("in_ready_idle", in_ready, 1);
    if (mode == M_SAME) begin
      w_we = 1'b1; w_class = wc[0:0]; w_idx = wi[4:0]; w_data = wd[3:0];
    end
    if (mode != M_RESET) sb.push_back(e);
    in_data  = img;
    in_valid = 1'b1;
    @(posedge clk_tb);
    n = 1;
    @(negedge clk_tb);
    in_valid = 1'b0;
    w_we     = 1'b0;
    check("in_ready_busy", in_ready, 0);
    if (mode == M_SAME) check("w_err_same_cycle", w_err, 0);
    while (!out_valid && n < 100) begin
      if (mode == M_WRITE && n == 3) begin
        w_we = 1'b1; w_class = wc[0:0]; w_idx = wi[4:0]; w_data = wd[3:0];
      end
      if (mode == M_WRITE && n == 4) begin
        w_we = 1'b0;
        check("w_err_pulse", w_err, 1);
      end
      if (mode == M_WRITE && n == 5) check("w_err_cleared", w_err, 0);
      if (mode == M_RESET && n == 10) begin
        rst_n = 1'b0;
        @(posedge clk_tb);
        @(negedge clk_tb);
        check("in_ready_in_reset", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk_tb);
        @(negedge clk_tb);
        check("in_ready_after_reset", in_ready, 1);
        check("out_score_after_reset", int'(out_score), 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
          if (out_valid) n++;
          @(posedge clk_tb);
          @(negedge clk_tb);
        end
        check("no_result_after_reset", n, 0);
        model_clear();
        return;
      end
      @(posedge clk_tb);
      n++;
      @(negedge clk_tb);
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      if (sb.size() > 0) got = sb.pop_front();
    end else begin
      check("latency", n, WIDTH + N_CLASSES);
      got = sb.pop_front();
      check("out_class", int'(out_class), got.cls);
      check("out_score", int'(out_score), got.score);
    end
    out_ready = 1'b1;
    @(posedge clk_tb);
    @(negedge clk_tb);
    out_ready = 1'b0;
    check("out_valid_cleared", out_valid, 0);
  endtask

  task automatic hold_test(input logic [24:0] img);
    exp_t got;
    int   n;
    sb.push_back(model(img));
    in_data = img; in_valid = 1'b1;
    @(posedge clk_tb);
    @(negedge clk_tb);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk_tb);
      n++;
      @(negedge clk_tb);
    end
    got = sb.pop_front();
    if (!out_valid) begin
      check("hold_timeout", 0, 1);
    end else begin
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1;
        in_data  = 25'h1FFFFFF;
        check("hold_valid", out_valid, 1);
        check("hold_class", int'(out_class), got.cls);
        check("hold_score", int'(out_score), got.score);
        check("hold_in_ready", in_ready, 0);
        @(posedge clk_tb);
        @(negedge clk_tb);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk_tb);
    @(negedge clk_tb);
    out_ready = 1'b0;
    check("hold_released", out_valid, 0);
    check("second_image_not_taken", in_ready, 1);
  endtask

  initial begin
    int   cur;
    exp_t e;
    logic [24:0] img;

    tbl[0] = '{0, 25'h0454544, 0, 8};
    tbl[1] = '{0, 25'h1155151, 1, 10};
    tbl[2] = '{0, 25'h0000000, 0, 0};
    tbl[3] = '{1, 25'h1FFFFFF, 1, 25};
    tbl[4] = '{1, 25'h0000000, 0, 0};
    tbl[5] = '{1, 25'h0000001, 1, 1};
    tbl[6] = '{2, 25'h0000000, 0, 0};
    tbl[7] = '{2, 25'h1FFFFFF, 0, 0};

    model_clear();
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    w_we = 1'b0; w_class = '0; w_idx = '0; w_data = '0;
    @(posedge clk_tb);
    @(posedge clk_tb);
    @(negedge clk_tb);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_w_err", w_err, 0);
    check("rst_out_class", int'(out_class), 0);
    check("rst_out_score", int'(out_score), 0);
    rst_n = 1'b1;
    @(posedge clk_tb);
    @(negedge clk_tb);
    check("in_ready_after_rst", in_ready, 1);

    cur = -1;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].setup != cur) begin
        set_weights(tbl[i].setup);
        cur = tbl[i].setup;
      end
      e.cls = tbl[i].cls;
      e.score = tbl[i].score;
      run_image(tbl[i].img, e, M_NORM, 0, 0, 0);
    end

    // Weights are all zero here; a write on the accept cycle must be used.
    mw[1][0] = 7;
    e = model(25'h0000001);
    run_image(25'h0000001, e, M_SAME, 1, 0, 7);

    set_weights(0);
    e.cls = 0; e.score = 8;
    run_image(pat0, e, M_WRITE, 0, 2, -8);
    run_image(pat0, e, M_NORM, 0, 0, 0);

    hold_test(pat1);

    run_image(pat0, e, M_RESET, 0, 0, 0);
    e.cls = 0; e.score = 0;
    run_image(pat0, e, M_NORM, 0, 0, 0);

    set_weights(3);
    for (int i = 0; i < 4; i++) begin
      img = 25'($urandom);
      run_image(img, model(img), M_NORM, 0, 0, 0);
    end

    set_weights(2);
    write_w(0, 31, 5, 1'b1);
`ifdef PERCEPTRON_ARRAY_BIAS_EN
    write_w(1, 25, 3, 1'b0);
    e.cls = 1; e.score = 3;
`else
    write_w(1, 25, 3, 1'b1);
    e.cls = 0; e.score = 0;
`endif
    run_image(25'h0000000, e, M_NORM, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
